// File: rtl/id_decode_stage.sv
// MIPS32 decode stage: register-file addressing, control decode, write-back bypass,
// load-use stall detection and the ID/EX pipeline register.
module id_decode_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [31:0]       if_instr,
  input  logic [31:0]       if_pc4,
  output logic              id_ready,
  input  logic              flush,
  output logic [REG_AW-1:0] reg1_add,
  output logic [REG_AW-1:0] reg2_add,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_add,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [31:0]       ex_imm,
  output logic [REG_AW-1:0] ex_dest,
  output logic [2:0]        ex_alu_op,
  output logic              ex_alu_src,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_reg_write,
  output logic              ex_mem_to_reg,
  output logic              ex_branch,
  output logic              ex_illegal,
  output logic [31:0]       ex_pc4
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  function automatic logic signed [31:0] sext16(input logic signed [15:0] v);
    return 32'(v);
  endfunction

  // $0 always reads zero; otherwise a same-cycle write-back beats the register file.
  function automatic logic [DATA_W-1:0] sel_operand(
    input logic [REG_AW-1:0] addr,
    input logic [DATA_W-1:0] rf_data,
    input logic              wb_en,
    input logic [REG_AW-1:0] wb_addr,
    input logic [DATA_W-1:0] wb_val
  );
    if (addr == '0)                   return '0;
    else if (wb_en && wb_addr == addr) return wb_val;
    else                              return rf_data;
  endfunction

  // ---- Stage p0: combinational decode of the IF/ID instruction ----
  logic [5:0]        w_op_p0;
  logic [5:0]        w_funct_p0;
  logic [REG_AW-1:0] w_rs_p0;
  logic [REG_AW-1:0] w_rt_p0;
  logic [REG_AW-1:0] w_rd_p0;

  assign w_op_p0    = if_instr[31:26];
  assign w_funct_p0 = if_instr[5:0];
  assign w_rs_p0    = if_instr[25:21];
  assign w_rt_p0    = if_instr[20:16];
  assign w_rd_p0    = if_instr[15:11];

  assign reg1_add = w_rs_p0;
  assign reg2_add = w_rt_p0;

  logic [REG_AW-1:0] w_dest_p0;
  logic [2:0]        w_alu_op_p0;
  logic              w_alu_src_p0;
  logic              w_mem_read_p0;
  logic              w_mem_write_p0;
  logic              w_reg_write_p0;
  logic              w_mem_to_reg_p0;
  logic              w_branch_p0;
  logic              w_illegal_p0;
  logic              w_rt_used_p0;

  always_comb begin
    w_dest_p0       = '0;
    w_alu_op_p0     = ALU_ADD;
    w_alu_src_p0    = 1'b0;
    w_mem_read_p0   = 1'b0;
    w_mem_write_p0  = 1'b0;
    w_reg_write_p0  = 1'b0;
    w_mem_to_reg_p0 = 1'b0;
    w_branch_p0     = 1'b0;
    w_illegal_p0    = 1'b0;
    w_rt_used_p0    = 1'b0;
    unique case (w_op_p0)
      OP_RTYPE: begin
        w_rt_used_p0 = 1'b1;
        w_dest_p0    = w_rd_p0;
        w_reg_write_p0 = 1'b1;
        unique case (w_funct_p0)
          6'h20:   w_alu_op_p0 = ALU_ADD;
          6'h22:   w_alu_op_p0 = ALU_SUB;
          6'h24:   w_alu_op_p0 = ALU_AND;
          6'h25:   w_alu_op_p0 = ALU_OR;
          6'h2A:   w_alu_op_p0 = ALU_SLT;
          default: begin
            w_dest_p0      = '0;
            w_reg_write_p0 = 1'b0;
            w_illegal_p0   = 1'b1;
          end
        endcase
      end
      OP_LW: begin
        w_alu_src_p0    = 1'b1;
        w_mem_read_p0   = 1'b1;
        w_mem_to_reg_p0 = 1'b1;
        w_reg_write_p0  = 1'b1;
        w_dest_p0       = w_rt_p0;
      end
      OP_SW: begin
        w_alu_src_p0   = 1'b1;
        w_mem_write_p0 = 1'b1;
        w_rt_used_p0   = 1'b1;
      end
      OP_BEQ: begin
        w_alu_op_p0  = ALU_SUB;
        w_branch_p0  = 1'b1;
        w_rt_used_p0 = 1'b1;
      end
      OP_ADDI: begin
        w_alu_src_p0   = 1'b1;
        w_reg_write_p0 = 1'b1;
        w_dest_p0      = w_rt_p0;
      end
      default: w_illegal_p0 = 1'b1;
    endcase
  end

  // A load still in EX cannot forward in time, so a dependent instruction waits one cycle.
  logic w_stall_p0;
  logic w_load_p0;

  assign w_stall_p0 = ex_valid && ex_mem_read && (ex_dest != '0) && if_valid &&
                      ((ex_dest == w_rs_p0) || ((ex_dest == w_rt_p0) && w_rt_used_p0));
  assign id_ready   = !w_stall_p0;
  assign w_load_p0  = !flush && !w_stall_p0 && if_valid;

  // ---- Stage p1: ID/EX pipeline register ----
  logic              r_vld_p1;
  logic [DATA_W-1:0] r_rs_data_p1;
  logic [DATA_W-1:0] r_rt_data_p1;
  logic [31:0]       r_imm_p1;
  logic [REG_AW-1:0] r_dest_p1;
  logic [2:0]        r_alu_op_p1;
  logic              r_alu_src_p1;
  logic              r_mem_read_p1;
  logic              r_mem_write_p1;
  logic              r_reg_write_p1;
  logic              r_mem_to_reg_p1;
  logic              r_branch_p1;
  logic              r_illegal_p1;
  logic [31:0]       r_pc4_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset || !w_load_p0) begin
      r_vld_p1        <= 1'b0;
      r_rs_data_p1    <= '0;
      r_rt_data_p1    <= '0;
      r_imm_p1        <= '0;
      r_dest_p1       <= '0;
      r_alu_op_p1     <= '0;
      r_alu_src_p1    <= 1'b0;
      r_mem_read_p1   <= 1'b0;
      r_mem_write_p1  <= 1'b0;
      r_reg_write_p1  <= 1'b0;
      r_mem_to_reg_p1 <= 1'b0;
      r_branch_p1     <= 1'b0;
      r_illegal_p1    <= 1'b0;
      r_pc4_p1        <= '0;
    end else begin
      r_vld_p1        <= 1'b1;
      r_rs_data_p1    <= sel_operand(w_rs_p0, read_data1, wb_reg_write, wb_add, wb_data);
      r_rt_data_p1    <= sel_operand(w_rt_p0, read_data2, wb_reg_write, wb_add, wb_data);
      r_imm_p1        <= sext16(if_instr[15:0]);
      r_dest_p1       <= w_dest_p0;
      r_alu_op_p1     <= w_alu_op_p0;
      r_alu_src_p1    <= w_alu_src_p0;
      r_mem_read_p1   <= w_mem_read_p0;
      r_mem_write_p1  <= w_mem_write_p0;
      r_reg_write_p1  <= w_reg_write_p0;
      r_mem_to_reg_p1 <= w_mem_to_reg_p0;
      r_branch_p1     <= w_branch_p0;
      r_illegal_p1    <= w_illegal_p0;
      r_pc4_p1        <= if_pc4;
    end
  end

  assign ex_valid      = r_vld_p1;
  assign ex_rs_data    = r_rs_data_p1;
  assign ex_rt_data    = r_rt_data_p1;
  assign ex_imm        = r_imm_p1;
  assign ex_dest       = r_dest_p1;
  assign ex_alu_op     = r_alu_op_p1;
  assign ex_alu_src    = r_alu_src_p1;
  assign ex_mem_read   = r_mem_read_p1;
  assign ex_mem_write  = r_mem_write_p1;
  assign ex_reg_write  = r_reg_write_p1;
  assign ex_mem_to_reg = r_mem_to_reg_p1;
  assign ex_branch     = r_branch_p1;
  assign ex_illegal    = r_illegal_p1;
  assign ex_pc4        = r_pc4_p1;

endmodule
